// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle CPU.
//   - INSTR_W and the instruction field positions (op/rd/ra/rb/imm8)
//   - opcode_e : 4-bit opcode encoding
//   - state_e  : controller FSM states
//   - flags_t  : carry/zero/negative flag bundle
//   - is_alu_op: true for the opcodes that compute through the ALU and write flags
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Instruction field positions. Register fields are 4 bits wide; the core
  // uses only the low log2(NREG) bits of each.
  localparam int OP_LSB  = 12;
  localparam int OP_W    = 4;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD    = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_OR     = 4'h4,
    OP_XOR    = 4'h5,
    OP_LDI    = 4'h6,
    OP_LD     = 4'h7,
    OP_ST     = 4'h8,
    OP_JMP    = 4'h9,
    OP_JZ     = 4'hA,
    OP_JC     = 4'hB,
    OP_OUT    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } flags_t;

  function automatic logic is_alu_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for the multi-cycle CPU.
//   op     : opcode (only ADD/SUB/AND/OR/XOR produce a result; others give 0)
//   a, b   : operands, DATA_W bits
//   result : DATA_W-bit result
//   c      : ADD carry-out / SUB borrow (a < b unsigned); 0 for logic ops
//   z      : result == 0
//   n      : result MSB
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z,
  output logic              n
);

  // One extra bit catches the carry (ADD) or the borrow (SUB).
  logic [DATA_W:0] wide;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    wide   = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: ;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DATA_W-1];

endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle CPU core, fixed 16-bit instructions.
// A controller FSM sequences FETCH/DECODE/EXEC/MEM/WB (plus an absorbing
// HALT). Instruction and data memories are external, behind req/ack
// handshakes, so wait-state memories are supported.
//   clk, reset_CPU_n            : clock, asynchronous active-low reset
//   imem_req/addr/rdata/ack     : instruction fetch port (addr = pc)
//   dmem_req/we/addr/wdata/rdata/ack : data port (addr = R[ra], wdata = R[rd])
//   output_port                 : value written by OUT
//   carrier_flag/zero_flag/negative_flag : flags from the last ALU op
//   halted                      : core sits in HALT
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 16,
  parameter int PC_W   = 8
) (
  input  logic               clk,
  input  logic               reset_CPU_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [DATA_W-1:0]  output_port,
  output logic               carrier_flag,
  output logic               zero_flag,
  output logic               negative_flag,
  output logic               halted
);

  localparam int RIDX_W = $clog2(NREG);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  // Operands captured in DECODE: R[ra], R[rb] and R[rd] (store data).
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  wd_q, wd_d;
  // Result register feeding the register-file write in WB.
  logic [DATA_W-1:0]  res_q, res_d;
  logic [DATA_W-1:0]  out_q, out_d;
  flags_t             flags_q, flags_d;
  logic [DATA_W-1:0]  rf_q [NREG];
  logic               rf_we;

  // Instruction fields decoded from the latched instruction.
  opcode_e           op;
  logic [RIDX_W-1:0] rd_idx, ra_idx, rb_idx;
  logic [IMM_W-1:0]  imm8;

  assign op     = opcode_e'(ir_q[OP_LSB +: OP_W]);
  assign rd_idx = ir_q[RD_LSB +: RIDX_W];
  assign ra_idx = ir_q[RA_LSB +: RIDX_W];
  assign rb_idx = ir_q[RB_LSB +: RIDX_W];
  assign imm8   = ir_q[IMM_LSB +: IMM_W];

  logic [DATA_W-1:0] alu_result;
  logic              alu_c, alu_z, alu_n;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z),
    .n      (alu_n)
  );

  // --------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    res_d   = res_q;
    out_d   = out_q;
    flags_d = flags_q;
    rf_we   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        a_d     = rf_q[ra_idx];
        b_d     = rf_q[rb_idx];
        wd_d    = rf_q[rd_idx];
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_alu_op(op)) begin
          res_d   = alu_result;
          flags_d = '{c: alu_c, z: alu_z, n: alu_n};
          state_d = ST_WB;
        end else begin
          case (op)
            OP_LDI: begin
              res_d   = DATA_W'(imm8);
              state_d = ST_WB;
            end
            OP_LD, OP_ST: state_d = ST_MEM;
            // Jumps test the flags as they stand now, i.e. those left by the
            // most recent ALU instruction; taken or not, fetch is next.
            OP_JMP: begin
              pc_d    = PC_W'(imm8);
              state_d = ST_FETCH;
            end
            OP_JZ: begin
              if (flags_q.z) pc_d = PC_W'(imm8);
              state_d = ST_FETCH;
            end
            OP_JC: begin
              if (flags_q.c) pc_d = PC_W'(imm8);
              state_d = ST_FETCH;
            end
            OP_OUT: begin
              out_d   = a_q;
              state_d = ST_FETCH;
            end
            OP_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;  // NOP and reserved opcodes
          endcase
        end
      end

      ST_MEM: begin
        if (dmem_ack) begin
          if (op == OP_LD) begin
            res_d   = dmem_rdata;
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        rf_we   = 1'b1;
        state_d = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_CPU_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    if (!reset_CPU_n) state_q <= ST_FETCH;
    else              state_q <= state_d;
  end

  // --------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_CPU_n) begin
    if (!reset_CPU_n) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      res_q   <= res_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  // --------------------------------------------------------------------
  // Register file: written only in WB, from the result register.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_CPU_n) begin
    // NOTE: this array is reset because software relies on every register
    // starting at zero; that forces flops rather than a RAM macro, which is
    // acceptable for at most 16 entries.
    if (!reset_CPU_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd_idx] <= res_q;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  // State already reads FETCH during reset, so the requests are also gated
  // by reset_CPU_n: they drop the moment reset asserts, and the first fetch
  // request appears in the first cycle after release.
  assign imem_req      = reset_CPU_n && (state_q == ST_FETCH);
  assign imem_addr     = pc_q;
  assign dmem_req      = reset_CPU_n && (state_q == ST_MEM);
  assign dmem_we       = (state_q == ST_MEM) && (op == OP_ST);
  assign dmem_addr     = PC_W'(a_q);
  assign dmem_wdata    = wd_q;
  assign output_port   = out_q;
  assign carrier_flag  = flags_q.c;
  assign zero_flag     = flags_q.z;
  assign negative_flag = flags_q.n;
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle (DATA_W=8, NREG=16, PC_W=8).
// Behavioural instruction/data memories with programmable wait states.
// Each test loads a program and pushes the expected fetch stream
// (address, cycles since previous fetch, output_port and flags seen at that
// fetch) plus expected data accesses into queues; the run loop pops and
// compares them as the core issues requests.
module tb_cpu_multicycle;
  import cpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int NREG   = 16;
  localparam int PC_W   = 8;

  logic               clk = 1'b0;
  logic               reset_CPU_n = 1'b0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;
  logic               dmem_req;
  logic               dmem_we;
  logic [PC_W-1:0]    dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  output_port;
  logic               carrier_flag, zero_flag, negative_flag;
  logic               halted;

  always #5 clk = ~clk;

  cpu_multicycle #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) dut (
    .clk           (clk),
    .reset_CPU_n   (reset_CPU_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .output_port   (output_port),
    .carrier_flag  (carrier_flag),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .halted        (halted)
  );

  // ---------------- memory models ----------------
  logic [INSTR_W-1:0] imem [256];
  logic [DATA_W-1:0]  dmem [256];
  int imem_wait = 0, dmem_wait = 0;
  int icnt = 0, dcnt = 0;

  assign imem_ack   = imem_req && (icnt >= imem_wait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (imem_req && !imem_ack) icnt <= icnt + 1;
    else                       icnt <= 0;
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else                       dcnt <= 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [PC_W-1:0]   addr;
    int                gap;
    logic [DATA_W-1:0] out;
    logic [2:0]        flags;   // {c, z, n}
  } fetch_t;

  typedef struct {
    logic              we;
    logic [PC_W-1:0]   addr;
    logic [DATA_W-1:0] wdata;
  } dacc_t;

  fetch_t fetch_q[$];
  dacc_t  dacc_q[$];
  int total = 0;
  int passed = 0;

  function automatic void push_f(input logic [PC_W-1:0] addr, input int gap,
                                 input logic [DATA_W-1:0] out, input logic [2:0] flags);
    fetch_t e;
    e.addr = addr; e.gap = gap; e.out = out; e.flags = flags;
    fetch_q.push_back(e);
  endfunction

  function automatic void push_d(input logic we, input logic [PC_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
    dacc_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    dacc_q.push_back(e);
  endfunction

  task automatic hold_reset();
    @(negedge clk);
    reset_CPU_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;  // stray fetches halt
    imem_wait = 0;
    dmem_wait = 0;
    fetch_q.delete();
    dacc_q.delete();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_CPU_n = 1'b1;
  endtask

  // Called right after release; cycle 0 is the first cycle out of reset.
  task automatic score_run(input int max_cyc);
    int last = -1;
    fetch_t fe;
    dacc_t  de;
    for (int c = 0; c < max_cyc && fetch_q.size() > 0; c++) begin
      #1;
      if (dmem_req) begin
        total++;
        if (dacc_q.size() == 0) begin
          $display("FAIL dmem_unexpected: request addr=%0h we=%0b with no access expected",
                   dmem_addr, dmem_we);
        end else begin
          de = dacc_q[0];
          if (dmem_we !== de.we || dmem_addr !== de.addr || (de.we && dmem_wdata !== de.wdata))
            $display("FAIL dmem_access: got we=%0b addr=%0h wdata=%0h, expected we=%0b addr=%0h wdata=%0h",
                     dmem_we, dmem_addr, dmem_wdata, de.we, de.addr, de.wdata);
          else passed++;
          if (dmem_ack) void'(dacc_q.pop_front());
        end
      end
      if (imem_req && imem_ack) begin
        fe = fetch_q.pop_front();
        total++;
        if (imem_addr !== fe.addr || (c - last) !== fe.gap)
          $display("FAIL fetch: got addr=%0h gap=%0d, expected addr=%0h gap=%0d",
                   imem_addr, c - last, fe.addr, fe.gap);
        else passed++;
        total++;
        if (output_port !== fe.out || {carrier_flag, zero_flag, negative_flag} !== fe.flags)
          $display("FAIL state_at_fetch %0h: got out=%0h czn=%03b, expected out=%0h czn=%03b",
                   fe.addr, output_port, {carrier_flag, zero_flag, negative_flag}, fe.out, fe.flags);
        else passed++;
        last = c;
      end
      @(negedge clk);
    end
    total++;
    if (fetch_q.size() != 0 || dacc_q.size() != 0) begin
      $display("FAIL run_timeout: %0d fetches and %0d data accesses still outstanding",
               fetch_q.size(), dacc_q.size());
      fetch_q.delete();
      dacc_q.delete();
    end else passed++;
  endtask

  task automatic expect_halted(input string name);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL %s_halt: got halted=%0b imem_req=%0b dmem_req=%0b, expected 1 0 0",
               name, halted, imem_req, dmem_req);
    else passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hold_reset();
    #1;
    total++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL reset_req_low: got imem_req=%0b dmem_req=%0b, expected 0 0", imem_req, dmem_req);
    else passed++;
    release_reset();
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL reset_first_fetch: got req=%0b addr=%0h, expected req=1 addr=0", imem_req, imem_addr);
    else passed++;
    total++;
    if (output_port !== 8'h00 || carrier_flag !== 1'b0 || zero_flag !== 1'b0 ||
        negative_flag !== 1'b0 || halted !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL reset_outputs: got out=%0h c=%0b z=%0b n=%0b halted=%0b dreq=%0b, expected all 0",
               output_port, carrier_flag, zero_flag, negative_flag, halted, dmem_req);
    else passed++;
    expect_halted("reset");
  endtask

  task automatic test_arith();
    hold_reset();
    imem[0] = 16'h61F0;  // LDI R1,0xF0
    imem[1] = 16'h6220;  // LDI R2,0x20
    imem[2] = 16'h1312;  // ADD R3,R1,R2 -> 0x10, C=1
    imem[3] = 16'hC030;  // OUT R3
    imem[4] = 16'hB008;  // JC 0x08 (taken)
    imem[8] = 16'hF000;  // HALT
    push_f(8'h00, 1, 8'h00, 3'b000);
    push_f(8'h01, 4, 8'h00, 3'b000);
    push_f(8'h02, 4, 8'h00, 3'b000);
    push_f(8'h03, 4, 8'h00, 3'b100);
    push_f(8'h04, 3, 8'h10, 3'b100);
    push_f(8'h08, 3, 8'h10, 3'b100);
    release_reset();
    score_run(200);
    expect_halted("arith");
    total++;
    if (output_port !== 8'h10 || {carrier_flag, zero_flag, negative_flag} !== 3'b100)
      $display("FAIL arith_result: got out=%0h czn=%03b, expected out=10 czn=100",
               output_port, {carrier_flag, zero_flag, negative_flag});
    else passed++;
  endtask

  task automatic test_logic();
    hold_reset();
    imem[0]  = 16'h61F0;  // LDI R1,0xF0
    imem[1]  = 16'h623C;  // LDI R2,0x3C
    imem[2]  = 16'h1711;  // ADD R7,R1,R1 -> 0xE0, C=1 N=1
    imem[3]  = 16'h3312;  // AND R3 -> 0x30, C cleared
    imem[4]  = 16'hC030;  // OUT R3
    imem[5]  = 16'h4412;  // OR R4 -> 0xFC
    imem[6]  = 16'hC040;  // OUT R4
    imem[7]  = 16'h5512;  // XOR R5 -> 0xCC
    imem[8]  = 16'h5655;  // XOR R6,R5,R5 -> 0, Z=1
    imem[9]  = 16'hC050;  // OUT R5
    push_f(8'h00, 1, 8'h00, 3'b000);
    push_f(8'h01, 4, 8'h00, 3'b000);
    push_f(8'h02, 4, 8'h00, 3'b000);
    push_f(8'h03, 4, 8'h00, 3'b101);
    push_f(8'h04, 4, 8'h00, 3'b000);
    push_f(8'h05, 3, 8'h30, 3'b000);
    push_f(8'h06, 4, 8'h30, 3'b001);
    push_f(8'h07, 3, 8'hFC, 3'b001);
    push_f(8'h08, 4, 8'hFC, 3'b001);
    push_f(8'h09, 4, 8'hFC, 3'b010);
    push_f(8'h0A, 3, 8'hCC, 3'b010);
    release_reset();
    score_run(300);
    expect_halted("logic");
  endtask

  task automatic test_sub_flags();
    hold_reset();
    imem[8'h00] = 16'h6133;  // LDI R1,0x33
    imem[8'h01] = 16'h6234;  // LDI R2,0x34
    imem[8'h02] = 16'h2412;  // SUB R4,R1,R2 -> 0xFF, borrow
    imem[8'h03] = 16'hB020;  // JC 0x20 (taken)
    imem[8'h20] = 16'h2311;  // SUB R3,R1,R1 -> 0, Z=1 C=0
    imem[8'h21] = 16'hA010;  // JZ 0x10 (taken)
    imem[8'h10] = 16'hB040;  // JC 0x40 (not taken)
    imem[8'h11] = 16'hC040;  // OUT R4
    push_f(8'h00, 1, 8'h00, 3'b000);
    push_f(8'h01, 4, 8'h00, 3'b000);
    push_f(8'h02, 4, 8'h00, 3'b000);
    push_f(8'h03, 4, 8'h00, 3'b101);
    push_f(8'h20, 3, 8'h00, 3'b101);
    push_f(8'h21, 4, 8'h00, 3'b010);
    push_f(8'h10, 3, 8'h00, 3'b010);
    push_f(8'h11, 3, 8'h00, 3'b010);
    push_f(8'h12, 3, 8'hFF, 3'b010);
    release_reset();
    score_run(300);
    expect_halted("sub");
  endtask

  task automatic test_memory_waits();
    hold_reset();
    dmem_wait = 3;
    imem[0] = 16'h6105;  // LDI R1,0x05
    imem[1] = 16'h62AA;  // LDI R2,0xAA
    imem[2] = 16'h8210;  // ST [R1]=R2
    imem[3] = 16'h7410;  // LD R4,[R1]
    imem[4] = 16'hC040;  // OUT R4
    push_f(8'h00, 1, 8'h00, 3'b000);
    push_f(8'h01, 4, 8'h00, 3'b000);
    push_f(8'h02, 4, 8'h00, 3'b000);
    push_f(8'h03, 7, 8'h00, 3'b000);
    push_f(8'h04, 8, 8'h00, 3'b000);
    push_f(8'h05, 3, 8'hAA, 3'b000);
    push_d(1'b1, 8'h05, 8'hAA);
    push_d(1'b0, 8'h05, 8'h00);
    release_reset();
    score_run(300);
    expect_halted("mem");
    total++;
    if (dmem[5] !== 8'hAA)
      $display("FAIL mem_stored: got mem[5]=%0h, expected aa", dmem[5]);
    else passed++;
  endtask

  task automatic test_wrap_halt();
    int bad = 0;
    hold_reset();
    imem_wait = 1;
    imem[8'h00] = 16'hA010;  // JZ 0x10: not taken first, taken after SUB
    imem[8'h01] = 16'h90FF;  // JMP 0xFF
    imem[8'hFF] = 16'h2000;  // SUB R0,R0,R0 -> Z=1; pc wraps to 0x00
    push_f(8'h00, 2, 8'h00, 3'b000);
    push_f(8'h01, 4, 8'h00, 3'b000);
    push_f(8'hFF, 4, 8'h00, 3'b000);
    push_f(8'h00, 5, 8'h00, 3'b010);
    push_f(8'h10, 4, 8'h00, 3'b010);
    release_reset();
    score_run(300);
    expect_halted("wrap");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL halt_absorbing: got %0d cycles with a request or halted low, expected 0", bad);
    else passed++;
  endtask

  task automatic test_mid_fetch_reset();
    hold_reset();
    imem[8'h00] = 16'h9030;  // JMP 0x30
    release_reset();
    @(negedge clk);          // DECODE
    imem_wait = 50;
    @(negedge clk);          // EXEC
    @(negedge clk);          // FETCH at 0x30, ack pending
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h30 || imem_ack !== 1'b0)
      $display("FAIL midreset_pending: got req=%0b addr=%0h ack=%0b, expected req=1 addr=30 ack=0",
               imem_req, imem_addr, imem_ack);
    else passed++;
    #2 reset_CPU_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL midreset_req_drop: got imem_req=%0b dmem_req=%0b, expected 0 0", imem_req, dmem_req);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    imem_wait = 0;
    reset_CPU_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL midreset_refetch: got req=%0b addr=%0h, expected req=1 addr=0", imem_req, imem_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_sub_flags();
    test_memory_waits();
    test_wrap_halt();
    test_mid_fetch_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle CPU top. Instructions are fixed 16-bit. Data width, register count and PC width are generics. Instruction and data memories sit outside the core behind req/ack handshakes, so wait-state memories are supported. A controller FSM sequences FETCH/DECODE/EXEC/MEM/WB and drives the output port and the carry/zero/negative flags.

## Interface
- DATA_W, 8: datapath and register width; must be at least 8.
- NREG, 16: number of general registers; power of two, 2..16.
- PC_W, 8: PC and memory address width; must be at least 8.
- clk  in  1  rising-edge clock
- reset_CPU_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (current PC)
- imem_rdata  in  16  instruction word
- imem_ack  in  1  fetch complete; rdata valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  PC_W  low PC_W bits of R[ra]
- dmem_wdata  out  DATA_W  R[rd]
- dmem_rdata  in  DATA_W  read data
- dmem_ack  in  1  access complete; rdata valid this cycle if read
- output_port  out  DATA_W  registered OUT value
- carrier_flag, zero_flag, negative_flag  out  1 each  registered ALU flags
- halted  out  1  core is in HALT

## Operation
- Instruction fields:
  - op = [15:12], rd = [11:8], ra = [7:4], rb = [3:0], imm8 = [7:0].
  - Register indices use the low log2(NREG) bits.
  - imm8 is zero-extended to DATA_W or PC_W as needed.
- Opcodes:
  - 0 NOP
  - 1 ADD: rd = ra + rb
  - 2 SUB: rd = ra − rb
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI: rd = imm8
  - 7 LD: rd = mem[R[ra]]
  - 8 ST: mem[R[ra]] = R[rd]
  - 9 JMP: pc = imm8
  - A JZ: jump if zero_flag
  - B JC: jump if carrier_flag
  - C OUT: output_port = R[ra]
  - D and E: reserved, executed as NOP
  - F HALT
- Flags:
  - Written only by opcodes 1–5.
  - ADD: C = carry out of bit DATA_W−1.
  - SUB: C = borrow, i.e. 1 when R[ra] < R[rb] unsigned.
  - Logic ops clear C.
  - Z = result == 0; N = result[DATA_W−1].
- FSM states and transitions:
  - FETCH: assert imem_req. On imem_ack, latch the instruction, set pc = pc+1 (wraps modulo 2^PC_W), go to DECODE.
  - DECODE: read the register operands, go to EXEC.
  - EXEC: ALU/LDI result into the result register → WB. OUT writes output_port → FETCH. A jump, taken or not, → FETCH; a taken jump overrides pc. LD/ST → MEM. NOP/reserved → FETCH. HALT → HALT.
  - MEM: assert dmem_req, with dmem_we=1 for ST. On dmem_ack, LD → WB (latch rdata) and ST → FETCH.
  - WB: write rd, → FETCH.
  - HALT: absorbing. All requests stay low; only reset exits.
- Handshake rules:
  - req stays high and addr/we/wdata stay stable until ack is sampled high.
  - ack may already be high in the first req cycle (zero-wait slave).
  - ack sampled while req is low is ignored.
- Register file: no hardwired zero register. R[rd] is written only in WB.
- Reset (asserted at any time, including mid-transaction):
  - Cleared to 0: pc, all registers, flags, output_port, halted.
  - State goes to FETCH. imem_req and dmem_req drop asynchronously.
  - First fetch request is the first cycle after deassertion, at address 0.

## Timing
- Cycles per instruction with zero-wait memory:
  - ALU / LDI = 4
  - LD = 5
  - ST = 4
  - OUT / jump / NOP = 3
  - HALT enters HALT after 3.
- Each wait cycle on imem_ack or dmem_ack adds one cycle.
- Register, flag and output_port updates appear on the clock edge that leaves WB or EXEC respectively.
- A jump condition uses the flags as they stand at EXEC. This means the result of the immediately preceding ALU instruction.
- imem_addr = pc throughout FETCH. The increment is visible from DECODE onward.

## Structure
- Shared package cpu_pkg holds:
  - opcode enum and state enum
  - field bit positions
  - INSTR_W = 16
- One sub-module, cpu_alu: combinational, DATA_W generic. Inputs op, a, b; outputs result, c, z, n.
- The register file and FSM live inside cpu_multicycle.

## Test plan
- Reset: release, zero-wait memory → imem_req=1, imem_addr=0 in the first cycle; all outputs 0.
- Arithmetic, DATA_W=8:
  - Program: LDI R1,0xF0; LDI R2,0x20; ADD R3,R1,R2; OUT R3.
  - Required: output_port=0x10, C=1, Z=0, N=0.
  - Total 4+4+4+3 cycles.
- SUB and flags: SUB R3,R1,R1 → Z=1, C=0. Then JZ 0x10 → next imem_addr=0x10. JC not taken → pc continues sequentially.
- Memory with waits:
  - Program: ST [R1]=R2, then LD R4,[R1] with R1=0x05, R2=0xAA; dmem_ack delayed 3 cycles.
  - Required: dmem_addr/we/wdata stable while waiting, R4=0xAA, the LD takes 8 cycles.
- Wrap and halt:
  - Required: PC_W=8 fetch at 0xFF increments pc to 0x00.
  - Required: HALT → halted=1, no further requests over 20 cycles.
- Mid-fetch reset: assert reset_CPU_n=0 while imem_req=1 and ack is pending → req low immediately; after release, the next fetch is at address 0.
